hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter NSTAGE, default 3, SHALL set the number of tracked stages after D (1=E, 2=M, 3=W, ...), legal range 2..6.
REQ-002 Parameter TW, default 3, SHALL set the width of all Tuse/Tnew fields.
REQ-003 Parameter MULT_LAT, default 5, SHALL set the multiply busy cycles; DIV_LAT, default 10, SHALL set the divide busy cycles.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 d_rs, d_rt  in  5 each  source register numbers of the instruction in D.
REQ-007 d_rs_tuse, d_rt_tuse  in  TW each  cycles until D's instruction consumes rs/rt; all-ones means unused.
REQ-008 d_a3, d_tnew  in  5, TW  destination register and its Tnew on entering E; d_a3=0 means no write.
REQ-009 d_md_start, d_md_div  in  1, 1  D instruction starts the MDU; div=1 selects divide latency.
REQ-010 d_md_use  in  1  D instruction reads HI/LO or starts the MDU.
REQ-011 stall  out  1  freeze PC and D; insert bubble into E.
REQ-012 fwd_rs_stage, fwd_rt_stage  out  3 each  youngest matching stage index 1..NSTAGE, 0 = none/register file.
REQ-013 md_busy  out  1  MDU timer non-zero.

Function
REQ-014 Each stage k SHALL hold {a3_k, tnew_k}; stage 1 SHALL load {d_a3, d_tnew} when stall=0 and {0, 0} when stall=1.
REQ-015 Stage k>1 SHALL load {a3_(k-1), sat_dec(tnew_(k-1))} every cycle; sat_dec SHALL saturate at 0, never wrap.
REQ-016 Stage NSTAGE contents SHALL be discarded on the next advance.
REQ-017 A stage SHALL match rs when a3_k != 0 and a3_k == d_rs; likewise for rt.
REQ-018 stall SHALL be 1 combinationally when any matching stage has tnew_k > the corresponding Tuse, using only the youngest (lowest k) match per operand.
REQ-019 fwd_*_stage SHALL give the lowest matching k regardless of stall; 0 when there is no match or the operand is register 0.
REQ-020 With the MDU feature, stall SHALL also be 1 when d_md_use=1 and md_busy=1.
REQ-021 When d_md_start=1 and stall=0, the MDU timer SHALL load MULT_LAT or DIV_LAT (per d_md_div) at the next edge; otherwise a non-zero timer decrements by 1.
REQ-022 A start accepted while the timer is non-zero SHALL NOT occur; REQ-020 guarantees this.
REQ-023 Outputs SHALL be purely a function of the current state and inputs, with zero added latency.

Reset
REQ-024 reset SHALL asynchronously clear all a3_k, tnew_k and the MDU timer to 0.
REQ-025 During and immediately after reset: stall=0, fwd_*_stage=0, md_busy=0.
REQ-026 reset asserted mid-stall or mid-MDU operation SHALL abort both; no residual stall.

Configuration
REQ-027 Macro HAZARD_MDU_EN defined: the MDU timer and REQ-020/021 SHALL be present.
REQ-028 Macro HAZARD_MDU_EN undefined: d_md_* inputs SHALL be ignored, md_busy SHALL be tied 0, and no timer register SHALL exist.

Structure
REQ-029 Shared package hazard_pkg SHALL hold TW default, MULT_LAT/DIV_LAT defaults, the TUSE_NONE constant (all ones) and the stage-index encoding (0=RF, 1=E, 2=M, 3=W).
REQ-030 Sub-module md_busy_timer SHALL implement the MDU counter: load, decrement, busy output.
REQ-031 Match/priority logic SHALL be a generate loop over NSTAGE, not a hand-coded per-stage copy.

Verification
REQ-032 Scenario lw-use: D=lw $8 (tnew 2), then add reading $8 (rs_tuse 1) -> stall=1 for exactly 1 cycle; then fwd_rs_stage=2.
REQ-033 Scenario ALU back-to-back: add $9 (tnew 1), then beq on $9 (tuse 0) -> 1 stall cycle; then fwd_rs_stage=2, no stall.
REQ-034 Scenario register 0: instruction writing $0 (tnew 2), then consumer of $0 -> stall=0, fwd=0.
REQ-035 Scenario youngest match: $5 written at both stage 1 (tnew 0) and stage 2 -> fwd_rt_stage=1.
REQ-036 Scenario MDU (HAZARD_MDU_EN): div start, then mfhi next cycle -> md_busy=1 and stall=1 for 10 cycles, then released; a mult start gives 5 cycles.
REQ-037 Scenario reset mid-divide: reset asserted on timer cycle 4 -> md_busy=0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: field widths, MDU latencies,
// the "operand unused" Tuse marker and the forwarding stage-index encoding.
package hazard_pkg;

  localparam int TW_DEF       = 3;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  localparam logic [TW_DEF-1:0] TUSE_NONE = '1;

  typedef enum logic [2:0] {
    STG_RF = 3'd0,
    STG_E  = 3'd1,
    STG_M  = 3'd2,
    STG_W  = 3'd3
  } stage_e;

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy counter: loads the operation latency on start and
// counts down to idle; busy while non-zero.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// Stall/forward decision for the D stage against NSTAGE tracked writers.
// Build with HAZARD_MDU_EN to add the multiply/divide busy interlock.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int TW       = TW_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic [4:0]    d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  output logic          stall,
  output logic [2:0]    fwd_rs_stage,
  output logic [2:0]    fwd_rt_stage,
  output logic          md_busy
);

  localparam logic [TW-1:0] TNONE = '1;

  logic [NSTAGE:1][4:0]    a3;
  logic [NSTAGE:1][TW-1:0] tnew;
  logic                    md_stall;

  // Writer shadow pipeline: a stall pushes a bubble into E, older stages
  // always advance with Tnew counting down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3   <= '0;
      tnew <= '0;
    end else begin
      a3[1]   <= stall ? 5'd0 : d_a3;
      tnew[1] <= stall ? '0 : d_tnew;
      for (int k = 2; k <= NSTAGE; k++) begin
        a3[k]   <= a3[k-1];
        tnew[k] <= (tnew[k-1] == '0) ? '0 : tnew[k-1] - TW'(1);
      end
    end
  end

  logic [NSTAGE:0] rs_m, rt_m;
  logic [NSTAGE:1] rs_win, rt_win, rs_hz, rt_hz;

  assign rs_m[0] = 1'b0;
  assign rt_m[0] = 1'b0;

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    assign rs_m[k]   = (a3[k] != 5'd0) && (a3[k] == d_rs);
    assign rt_m[k]   = (a3[k] != 5'd0) && (a3[k] == d_rt);
    // Only the youngest writer of an operand matters; older ones are shadowed.
    assign rs_win[k] = rs_m[k] & ~(|rs_m[k-1:0]);
    assign rt_win[k] = rt_m[k] & ~(|rt_m[k-1:0]);
    assign rs_hz[k]  = (d_rs_tuse != TNONE) && (tnew[k] > d_rs_tuse);
    assign rt_hz[k]  = (d_rt_tuse != TNONE) && (tnew[k] > d_rt_tuse);
  end

  always_comb begin
    fwd_rs_stage = 3'(STG_RF);
    fwd_rt_stage = 3'(STG_RF);
    for (int k = 1; k <= NSTAGE; k++) begin
      if (rs_win[k]) fwd_rs_stage = 3'(k);
      if (rt_win[k]) fwd_rt_stage = 3'(k);
    end
  end

  assign stall = (|(rs_win & rs_hz)) | (|(rt_win & rt_hz)) | md_stall;

`ifdef HAZARD_MDU_EN
  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (d_md_start & ~stall),
    .div   (d_md_div),
    .busy  (md_busy)
  );
  assign md_stall = d_md_use & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_md_start, d_md_div, d_md_use};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule
